// File: rtl/protocol_fifo_converter.sv
// rtl/protocol_fifo_converter.sv - show-ahead FIFO bridging pulse, valid/ready and four-phase handshakes
module protocol_fifo_converter #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 4,
    parameter int IN_PROTOCOL  = 2,
    parameter int OUT_PROTOCOL = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   src_in,
    output logic                   src_out,
    input  logic [DATA_WIDTH-1:0]  src_data,
    input  logic                   dst_in,
    output logic                   dst_out,
    output logic [DATA_WIDTH-1:0]  dst_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int AW          = $clog2(DEPTH);
    localparam int PULSE       = 1;
    localparam int VALID_READY = 2;
    localparam int HANDSHAKE   = 3;

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    if ((IN_PROTOCOL != PULSE) && (IN_PROTOCOL != VALID_READY) && (IN_PROTOCOL != HANDSHAKE)) begin : g_bad_in
        $error("IN_PROTOCOL must be 1, 2 or 3");
    end
    if ((OUT_PROTOCOL != PULSE) && (OUT_PROTOCOL != VALID_READY) && (OUT_PROTOCOL != HANDSHAKE)) begin : g_bad_out
        $error("OUT_PROTOCOL must be 1, 2 or 3");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (DATA_WIDTH < 1)) begin : g_bad_size
        $error("DEPTH must be a power of two >= 2 and DATA_WIDTH >= 1");
    end

    typedef enum logic {S_WAIT, S_ACK} src_state_e;
    typedef enum logic [1:0] {D_IDLE, D_REQ, D_DONE} dst_state_e;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  overflow_q, overflow_d;
    src_state_e            s_state_q, s_state_d;
    dst_state_e            d_state_q, d_state_d;
    logic                  full, empty, push, pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    always_comb begin
        s_state_d  = s_state_q;
        push       = 1'b0;
        src_out    = 1'b0;
        overflow_d = overflow_q;
        if (IN_PROTOCOL == HANDSHAKE) begin
            src_out = (s_state_q == S_ACK);
            case (s_state_q)
                S_WAIT: if (src_in && !full) begin
                    push      = 1'b1;
                    s_state_d = S_ACK;
                end
                S_ACK:  if (!src_in) s_state_d = S_WAIT;
            endcase
        end else begin
            src_out = !full;
            push    = src_in && !full;
            if ((IN_PROTOCOL == PULSE) && src_in && full) overflow_d = 1'b1;
        end
        if (rst) src_out = 1'b0;
    end

    always_comb begin
        d_state_d = d_state_q;
        pop       = 1'b0;
        dst_out   = 1'b0;
        if (OUT_PROTOCOL == HANDSHAKE) begin
            dst_out = (d_state_q == D_REQ);
            case (d_state_q)
                D_IDLE:  if (!empty && !dst_in) d_state_d = D_REQ;
                D_REQ:   if (dst_in) begin
                    pop       = 1'b1;
                    d_state_d = D_DONE;
                end
                D_DONE:  if (!dst_in) d_state_d = D_IDLE;
                default: d_state_d = D_IDLE;
            endcase
        end else if (OUT_PROTOCOL == PULSE) begin
            dst_out = !empty && dst_in;
            pop     = !empty && dst_in;
        end else begin
            dst_out = !empty;
            pop     = !empty && dst_in;
        end
        if (rst) dst_out = 1'b0;
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            s_state_q  <= S_WAIT;
            d_state_q  <= D_IDLE;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            s_state_q  <= s_state_d;
            d_state_q  <= d_state_d;
        end
    end

    // Storage carries no reset; reads of stale entries are masked by empty.
    always_ff @(posedge clk) begin
        if (push && !rst) mem_q[wr_ptr_q] <= src_data;
    end

    assign dst_data = (empty || rst) ? '0 : mem_q[rd_ptr_q];
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_protocol_fifo_converter.sv
// tb/tb_protocol_fifo_converter.sv - directed checks of protocol_fifo_converter across protocol pairings
module tb_protocol_fifo_converter;

    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic a_src_in, a_src_out, a_dst_in, a_dst_out, a_overflow;
    logic [DW-1:0] a_src_data, a_dst_data;
    logic [2:0] a_count;
    logic b_src_in, b_src_out, b_dst_in, b_dst_out, b_overflow;
    logic [DW-1:0] b_src_data, b_dst_data;
    logic [2:0] b_count;
    logic c_src_in, c_src_out, c_dst_in, c_dst_out, c_overflow;
    logic [DW-1:0] c_src_data, c_dst_data;
    logic [2:0] c_count;
    logic d_src_in, d_src_out, d_dst_in, d_dst_out, d_overflow;
    logic [DW-1:0] d_src_data, d_dst_data;
    logic [2:0] d_count;

    protocol_fifo_converter #(.DATA_WIDTH(DW), .DEPTH(4), .IN_PROTOCOL(2), .OUT_PROTOCOL(2)) u_vv (
        .clk(clk), .rst(rst), .src_in(a_src_in), .src_out(a_src_out), .src_data(a_src_data),
        .dst_in(a_dst_in), .dst_out(a_dst_out), .dst_data(a_dst_data), .count(a_count), .overflow(a_overflow));
    protocol_fifo_converter #(.DATA_WIDTH(DW), .DEPTH(4), .IN_PROTOCOL(1), .OUT_PROTOCOL(1)) u_pp (
        .clk(clk), .rst(rst), .src_in(b_src_in), .src_out(b_src_out), .src_data(b_src_data),
        .dst_in(b_dst_in), .dst_out(b_dst_out), .dst_data(b_dst_data), .count(b_count), .overflow(b_overflow));
    protocol_fifo_converter #(.DATA_WIDTH(DW), .DEPTH(4), .IN_PROTOCOL(3), .OUT_PROTOCOL(1)) u_hp (
        .clk(clk), .rst(rst), .src_in(c_src_in), .src_out(c_src_out), .src_data(c_src_data),
        .dst_in(c_dst_in), .dst_out(c_dst_out), .dst_data(c_dst_data), .count(c_count), .overflow(c_overflow));
    protocol_fifo_converter #(.DATA_WIDTH(DW), .DEPTH(4), .IN_PROTOCOL(2), .OUT_PROTOCOL(3)) u_vh (
        .clk(clk), .rst(rst), .src_in(d_src_in), .src_out(d_src_out), .src_data(d_src_data),
        .dst_in(d_dst_in), .dst_out(d_dst_out), .dst_data(d_dst_data), .count(d_count), .overflow(d_overflow));

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic          si;
        logic [DW-1:0] sd;
        logic          di;
        logic          so;
        logic          dout;
        logic [DW-1:0] dd;
        logic [2:0]    cnt;
    } vec_t;

    vec_t vecs[26];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] q[$];
        int pulses, sent, got, exp_cnt, cyc;
        logic do_push, do_pop;

        // VALID_READY -> VALID_READY: fill, blocked push, in-order drain, push+pop, full+pop
        vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};
        vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 3'd1};
        vecs[2]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11, 3'd2};
        vecs[3]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 8'h11, 3'd3};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 3'd4};
        vecs[5]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h11, 3'd4};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11, 3'd4};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 3'd3};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 3'd2};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44, 3'd1};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};
        vecs[11] = '{1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};
        vecs[12] = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 8'h66, 3'd1};
        vecs[13] = '{1'b1, 8'h88, 1'b1, 1'b1, 1'b1, 8'h66, 3'd2};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h77, 3'd2};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h88, 3'd1};
        vecs[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};
        vecs[17] = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};
        vecs[18] = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 8'hA1, 3'd1};
        vecs[19] = '{1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 8'hA1, 3'd2};
        vecs[20] = '{1'b1, 8'hA4, 1'b0, 1'b1, 1'b1, 8'hA1, 3'd3};
        vecs[21] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA1, 3'd4};
        vecs[22] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA2, 3'd3};
        vecs[23] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA3, 3'd2};
        vecs[24] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA4, 3'd1};
        vecs[25] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};

        rst = 1'b1;
        a_src_in = 0; a_src_data = '0; a_dst_in = 0;
        b_src_in = 0; b_src_data = '0; b_dst_in = 0;
        c_src_in = 0; c_src_data = '0; c_dst_in = 0;
        d_src_in = 0; d_src_data = '0; d_dst_in = 0;

        tick(); settle();
        chk("rst.a_src_out", a_src_out, 0);
        chk("rst.b_src_out", b_src_out, 0);
        chk("rst.a_dst_out", a_dst_out, 0);
        chk("rst.a_dst_data", a_dst_data, 0);
        chk("rst.a_count", a_count, 0);
        tick(); rst = 1'b0; settle();
        chk("post_rst.a_count", a_count, 0);
        chk("post_rst.a_src_out", a_src_out, 1);
        chk("post_rst.b_src_out", b_src_out, 1);
        chk("post_rst.c_src_out", c_src_out, 0);
        chk("post_rst.d_dst_out", d_dst_out, 0);
        chk("post_rst.b_overflow", b_overflow, 0);

        for (int i = 0; i < 26; i++) begin
            tick();
            a_src_in = vecs[i].si; a_src_data = vecs[i].sd; a_dst_in = vecs[i].di;
            settle();
            chk($sformatf("vv[%0d].src_out", i), a_src_out, vecs[i].so);
            chk($sformatf("vv[%0d].dst_out", i), a_dst_out, vecs[i].dout);
            chk($sformatf("vv[%0d].dst_data", i), a_dst_data, vecs[i].dd);
            chk($sformatf("vv[%0d].count", i), a_count, vecs[i].cnt);
        end

        // PULSE in: fifth strobe into a full FIFO is dropped and overflow sticks
        for (int k = 0; k < 4; k++) begin
            tick(); b_src_in = 1'b1; b_src_data = 8'(8'h11 * (k + 1));
        end
        tick(); b_src_data = 8'h55; settle();
        chk("pp.full_src_out", b_src_out, 0);
        chk("pp.full_count", b_count, 4);
        chk("pp.overflow_before", b_overflow, 0);
        tick(); b_src_in = 1'b0; settle();
        chk("pp.overflow_set", b_overflow, 1);
        chk("pp.count_after_drop", b_count, 4);
        for (int k = 0; k < 4; k++) begin
            tick(); b_dst_in = 1'b1; settle();
            chk($sformatf("pp.pop%0d.dst_out", k), b_dst_out, 1);
            chk($sformatf("pp.pop%0d.dst_data", k), b_dst_data, 8'(8'h11 * (k + 1)));
            chk($sformatf("pp.pop%0d.count", k), b_count, 4 - k);
        end
        tick(); settle();
        chk("pp.empty_dst_out", b_dst_out, 0);
        chk("pp.empty_dst_data", b_dst_data, 0);
        chk("pp.empty_count", b_count, 0);
        chk("pp.overflow_sticky", b_overflow, 1);
        b_dst_in = 1'b0;

        // HANDSHAKE -> PULSE: req held 6 cycles gives exactly one push
        tick(); c_src_in = 1'b1; c_src_data = 8'hA5; settle();
        chk("hp.ack_c0", c_src_out, 0);
        chk("hp.count_c0", c_count, 0);
        for (int k = 1; k < 6; k++) begin
            tick(); settle();
            chk($sformatf("hp.ack_c%0d", k), c_src_out, 1);
            chk($sformatf("hp.count_c%0d", k), c_count, 1);
        end
        tick(); c_src_in = 1'b0; settle();
        chk("hp.ack_after_req_low", c_src_out, 1);
        tick(); settle();
        chk("hp.ack_dropped", c_src_out, 0);
        chk("hp.count_single", c_count, 1);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            tick(); c_dst_in = 1'b1; settle();
            if (c_dst_out) begin
                pulses++;
                chk("hp.pulse_data", c_dst_data, 8'hA5);
            end
        end
        chk("hp.pulse_count", pulses, 1);
        chk("hp.drained", c_count, 0);
        c_dst_in = 1'b0;

        // VALID_READY -> HANDSHAKE: registered req, held until ack, next only after ack drops
        tick(); d_src_in = 1'b1; d_src_data = 8'h01; settle();
        chk("vh.src_out", d_src_out, 1);
        chk("vh.req_c0", d_dst_out, 0);
        tick(); d_src_data = 8'h02; settle();
        chk("vh.req_c1", d_dst_out, 0);
        chk("vh.count_c1", d_count, 1);
        tick(); d_src_in = 1'b0; settle();
        chk("vh.req_c2", d_dst_out, 1);
        chk("vh.data_c2", d_dst_data, 8'h01);
        chk("vh.count_c2", d_count, 2);
        repeat (2) tick();
        settle();
        chk("vh.req_hold", d_dst_out, 1);
        chk("vh.data_hold", d_dst_data, 8'h01);
        tick(); d_dst_in = 1'b1; settle();
        chk("vh.req_at_ack", d_dst_out, 1);
        tick(); settle();
        chk("vh.req_done", d_dst_out, 0);
        chk("vh.next_head", d_dst_data, 8'h02);
        chk("vh.count_after_pop", d_count, 1);
        tick(); d_dst_in = 1'b0; settle();
        chk("vh.no_req_ack_low", d_dst_out, 0);
        tick(); settle();
        chk("vh.no_req_idle", d_dst_out, 0);
        tick(); settle();
        chk("vh.req2", d_dst_out, 1);
        chk("vh.data2", d_dst_data, 8'h02);
        tick(); d_dst_in = 1'b1; settle();
        chk("vh.req2_at_ack", d_dst_out, 1);
        tick(); d_dst_in = 1'b0; settle();
        chk("vh.req2_done", d_dst_out, 0);
        chk("vh.count_end", d_count, 0);

        // pointer wrap: 3*DEPTH words with random stalls against a queue model
        sent = 0; got = 0; exp_cnt = 0; cyc = 0;
        while (got < 12 && cyc < 400) begin
            tick(); cyc++;
            a_src_in   = (sent < 12) && ($urandom_range(0, 3) != 0);
            a_src_data = 8'(8'hC0 + sent);
            a_dst_in   = ($urandom_range(0, 2) != 0);
            settle();
            chk("wrap.count", a_count, exp_cnt);
            chk("wrap.src_out", a_src_out, exp_cnt < 4);
            do_pop  = (exp_cnt > 0) && a_dst_in;
            do_push = a_src_in && (exp_cnt < 4);
            if (do_pop) begin
                chk($sformatf("wrap.data%0d", got), a_dst_data, q[0]);
                void'(q.pop_front());
                got++;
            end
            if (do_push) begin
                q.push_back(a_src_data);
                sent++;
            end
            exp_cnt = exp_cnt + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
        end
        chk("wrap.delivered", got, 12);
        a_src_in = 1'b0; a_dst_in = 1'b0;

        // reset with count=3 and a HANDSHAKE destination req outstanding
        tick(); d_src_in = 1'b1; d_src_data = 8'h03; c_src_in = 1'b1; c_src_data = 8'h5A;
        tick(); d_src_data = 8'h04;
        tick(); d_src_data = 8'h05;
        tick(); d_src_in = 1'b0; settle();
        chk("mid.count", d_count, 3);
        chk("mid.req", d_dst_out, 1);
        chk("mid.data", d_dst_data, 8'h03);
        chk("mid.c_ack", c_src_out, 1);
        tick(); rst = 1'b1; settle();
        chk("in_rst.d_dst_out", d_dst_out, 0);
        chk("in_rst.d_dst_data", d_dst_data, 0);
        chk("in_rst.d_src_out", d_src_out, 0);
        chk("in_rst.c_src_out", c_src_out, 0);
        tick(); rst = 1'b0; settle();
        chk("after_rst.d_count", d_count, 0);
        chk("after_rst.d_dst_out", d_dst_out, 0);
        chk("after_rst.d_dst_data", d_dst_data, 0);
        chk("after_rst.d_overflow", d_overflow, 0);
        chk("after_rst.b_overflow", b_overflow, 0);
        chk("after_rst.a_overflow", a_overflow, 0);
        chk("after_rst.c_overflow", c_overflow, 0);
        chk("after_rst.c_count", c_count, 0);
        chk("after_rst.c_src_out", c_src_out, 0);
        chk("after_rst.b_src_out", b_src_out, 1);
        tick(); settle();
        chk("req_reaccept.c_src_out", c_src_out, 1);
        chk("req_reaccept.c_count", c_count, 1);
        chk("req_reaccept.d_dst_out", d_dst_out, 0);
        c_src_in = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/protocol_fifo_converter.md
# protocol_fifo_converter

Multi-entry, parametrised successor to the single-register protocol converter. It accepts words on a source port speaking pulse, valid/ready or four-phase handshake. It buffers up to DEPTH words in a show-ahead FIFO and delivers them in order on a destination port speaking any of the same three protocols. It sits between compute stages with mismatched flow-control styles where single-entry buffering stalls the upstream stage.

## Interface
- DATA_WIDTH, 32, payload width in bits (≥1)
- DEPTH, 4, FIFO entries; power of two, ≥2
- IN_PROTOCOL, 2, source protocol: 1 = PULSE, 2 = VALID_READY, 3 = HANDSHAKE
- OUT_PROTOCOL, 2, destination protocol, same encoding
- Any other protocol value is an elaboration error.
- CW = $clog2(DEPTH)+1
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- src_in  input  1  PULSE: strobe; VALID_READY: valid; HANDSHAKE: req level
- src_out  output  1  PULSE/VALID_READY: ready; HANDSHAKE: ack
- src_data  input  DATA_WIDTH  source payload, sampled on accept
- dst_in  input  1  PULSE/VALID_READY: downstream ready; HANDSHAKE: ack
- dst_out  output  1  PULSE: strobe; VALID_READY: valid; HANDSHAKE: req
- dst_data  output  DATA_WIDTH  FIFO head; 0 when empty
- count  output  CW  current occupancy, 0..DEPTH
- overflow  output  1  sticky: a PULSE strobe was dropped because the FIFO was full

## Operation
- Storage: DEPTH-entry array with write pointer, read pointer and count.
  - Pointers wrap modulo DEPTH.
  - full = (count == DEPTH); empty = (count == 0).
- Push and pop in the same cycle leave count unchanged.
- No write-to-read bypass: a word pushed in cycle N is first visible on dst_data in cycle N+1.
- Source side:
  - PULSE:
    - src_out = ~full.
    - src_in & ~full pushes src_data.
    - src_in & full drops the word and sets overflow; overflow clears only on rst.
    - The upstream stage is expected to honour src_out.
  - VALID_READY:
    - src_out = ~full.
    - src_in & src_out pushes.
    - No push when full, even if a pop happens in the same cycle.
  - HANDSHAKE: registered ack, two states.
    - S_WAIT: accept when src_in & ~full; push, go to S_ACK.
    - S_ACK: src_out = 1; stay while src_in = 1; when src_in = 0, go to S_WAIT with src_out = 0 the next cycle.
    - A req that stays high never causes a second push.
- Destination side:
  - PULSE:
    - dst_out = ~empty & dst_in.
    - Each high cycle pops one word; dst_data is valid in that cycle.
    - Back-to-back pops are allowed, one per cycle.
  - VALID_READY:
    - dst_out = ~empty; pop when dst_out & dst_in.
    - dst_data is held stable while dst_out & ~dst_in.
  - HANDSHAKE: registered req, three states.
    - D_IDLE: if ~empty & ~dst_in, raise req and go to D_REQ.
    - D_REQ: req = 1 and dst_data is held; when dst_in = 1, pop, drop req, go to D_DONE.
    - D_DONE: wait for dst_in = 0, then go to D_IDLE.
- Empty FIFO: dst_out stays 0 in every mode.
- Full FIFO: src_out = 0 in PULSE and VALID_READY; in HANDSHAKE, src_out stays 0 for any new req.
- Reset mid-operation: the FIFO contents are discarded, count = 0 and both FSMs return to idle.
  - A source req still high after reset is treated as new and is accepted.
  - A destination transaction that was in flight is abandoned.

## Timing
- Reset values (during rst and in the first cycle after it):
  - count = 0, overflow = 0, dst_out = 0, dst_data = 0.
  - src_out = 0 while rst is high.
  - src_out = 1 on the first cycle after rst for PULSE/VALID_READY; 0 for HANDSHAKE.
- Latency, accept to dst_out (empty FIFO):
  - 1 cycle for VALID_READY, and for PULSE when dst_in = 1.
  - 2 cycles for HANDSHAKE out, because req is registered.
- Throughput: one word per cycle for PULSE/VALID_READY on both sides.
- HANDSHAKE source: at most one word every 4 cycles (req↑, ack↑, req↓, ack↓).
- HANDSHAKE destination: at most one word every 4 cycles, given a zero-latency responder.
- count and overflow are registered and update on the edge after the event.

## Test plan
- VALID_READY→VALID_READY, DEPTH=4:
  - Push 0x11, 0x22, 0x33, 0x44 with dst_in = 0 → count = 4, src_out = 0.
  - Then dst_in = 1 → 0x11..0x44 pop in order on 4 consecutive cycles, count returns to 0.
- PULSE in, FIFO full: fifth strobe with 0x55 → word dropped, overflow = 1 until rst, count stays 4.
- HANDSHAKE→PULSE:
  - Hold req high for 6 cycles with 0xA5 → exactly one push, ack high until 1 cycle after req↓.
  - dst_out pulses once with 0xA5.
- VALID_READY→HANDSHAKE: push 0x01, 0x02 → req↑ with 0x01, held until ack.
  - Next req only after ack↓.
  - Second transaction carries 0x02.
- Simultaneous push and pop at count = 2 → count stays 2, order preserved.
- Pointer wrap: 3×DEPTH words streamed with random stalls.
- rst asserted with count = 3 and a HANDSHAKE destination transaction in flight → next cycle count = 0, dst_out = 0, dst_data = 0, overflow = 0.
